fifo_fwft_mc: RTL and testbench

Multi-channel, single-clock, first-word-fall-through FIFO. NCHAN independent queues share one WIDTH-wide storage array of NCHAN*DEPTH entries. Each queue has its own status, an almost-full threshold, a per-channel flush, and sticky overflow/underflow flags. It sits between producers and consumers in the same clock domain, e.g. multi-port peripheral or DMA staging, and replaces per-channel instances of the basic FWFT FIFO.

---
 rtl/fifo_fwft_mc.sv | 114 +++++++++++
 tb/tb_fifo_fwft_mc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_mc.sv
// Multi-channel first-word-fall-through FIFO: NCHAN independent queues sharing
// one storage array, with per-channel status, flush and sticky error flags.
module fifo_fwft_mc #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  parameter  int NCHAN = 2,
  parameter  int AFULL = DEPTH - 1,
  localparam int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int UW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [CW-1:0]         pushchan_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  input  logic [CW-1:0]         popchan_i,
  output logic [WIDTH-1:0]      data_o,
  input  logic [NCHAN-1:0]      flush_i,
  input  logic                  clrerr_i,
  output logic [NCHAN-1:0]      empty_o,
  output logic [NCHAN-1:0]      full_o,
  output logic [NCHAN-1:0]      afull_o,
  output logic [NCHAN*UW-1:0]   usage_o,
  output logic [NCHAN-1:0]      ovf_o,
  output logic [NCHAN-1:0]      unf_o
);

  localparam int MW = $clog2(NCHAN * DEPTH);
  localparam logic [CW:0] NCHAN_W = (CW + 1)'(NCHAN);

  logic [UW-1:0]    rdidx_q [NCHAN];
  logic [UW-1:0]    rdidx_d [NCHAN];
  logic [UW-1:0]    wridx_q [NCHAN];
  logic [UW-1:0]    wridx_d [NCHAN];
  logic [UW-1:0]    usage   [NCHAN];
  logic [NCHAN-1:0] ovf_q, ovf_d;
  logic [NCHAN-1:0] unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [NCHAN*DEPTH];

  logic          push_chan_ok, pop_chan_ok;
  logic          push_req, push_acc, pop_req, pop_acc;
  logic [MW-1:0] wr_addr, rd_addr;

  // Status is a pure function of the indices, never of this cycle's requests.
  always_comb begin
    usage_o = '0;
    for (int c = 0; c < NCHAN; c++) begin
      usage[c]             = wridx_q[c] - rdidx_q[c];
      empty_o[c]           = (usage[c] == '0);
      full_o[c]            = (usage[c] == UW'(DEPTH));
      afull_o[c]           = (usage[c] >= UW'(AFULL));
      usage_o[c*UW +: UW]  = usage[c];
    end
  end

  assign push_chan_ok = ({1'b0, pushchan_i} < NCHAN_W);
  assign pop_chan_ok  = ({1'b0, popchan_i} < NCHAN_W);

  assign pop_req  = pop_i && pop_chan_ok && !flush_i[popchan_i];
  assign pop_acc  = pop_req && !empty_o[popchan_i];
  assign push_req = push_i && push_chan_ok && !flush_i[pushchan_i];
  // A full channel still takes a push when the same channel pops this cycle.
  assign push_acc = push_req &&
                    (!full_o[pushchan_i] || (pop_acc && (popchan_i == pushchan_i)));

  assign wr_addr = MW'({pushchan_i, wridx_q[pushchan_i][UW-2:0]});
  assign rd_addr = MW'({popchan_i, rdidx_q[popchan_i][UW-2:0]});
  assign data_o  = mem_q[rd_addr];
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      wridx_d[c] = wridx_q[c];
      rdidx_d[c] = rdidx_q[c];
      if (push_acc && (pushchan_i == CW'(c)))
        wridx_d[c] = wridx_q[c] + UW'(1);
      if (pop_acc && (popchan_i == CW'(c)))
        rdidx_d[c] = rdidx_q[c] + UW'(1);
      if (flush_i[c])
        rdidx_d[c] = wridx_d[c];
      ovf_d[c] = (ovf_q[c] && !clrerr_i) ||
                 (push_req && !push_acc && (pushchan_i == CW'(c)));
      unf_d[c] = (unf_q[c] && !clrerr_i) ||
                 (pop_req && empty_o[popchan_i] && (popchan_i == CW'(c)));
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < NCHAN; c++) begin
        rdidx_q[c] <= '0;
        wridx_q[c] <= '0;
      end
      ovf_q <= '0;
      unf_q <= '0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        rdidx_q[c] <= rdidx_d[c];
        wridx_q[c] <= wridx_d[c];
      end
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is deliberately left unreset; only the indices define contents.
  always_ff @(posedge clk_i) begin
    if (push_acc)
      mem_q[wr_addr] <= data_i;
  end

endmodule

// File: tb/tb_fifo_fwft_mc.sv
// Self-checking bench for fifo_fwft_mc: directed vector table, wrap loop,
// randomized traffic against a queue-based reference model, async reset.
module tb_fifo_fwft_mc;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int NCHAN = 2;
  localparam int AFULL = 3;
  localparam int UW    = 3;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             push_i, pop_i, clrerr_i;
  logic [0:0]       pushchan_i, popchan_i;
  logic [WIDTH-1:0] data_i, data_o;
  logic [NCHAN-1:0] flush_i, empty_o, full_o, afull_o, ovf_o, unf_o;
  logic [NCHAN*UW-1:0] usage_o;

  fifo_fwft_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCHAN(NCHAN), .AFULL(AFULL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(push_i), .pushchan_i(pushchan_i),
    .data_i(data_i), .pop_i(pop_i), .popchan_i(popchan_i), .data_o(data_o),
    .flush_i(flush_i), .clrerr_i(clrerr_i), .empty_o(empty_o), .full_o(full_o),
    .afull_o(afull_o), .usage_o(usage_o), .ovf_o(ovf_o), .unf_o(unf_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq [NCHAN][$];
  logic [NCHAN-1:0] movf, munf;
  logic [WIDTH-1:0] head_seen;

  typedef struct {
    bit       push;
    bit [0:0] pch;
    bit [7:0] din;
    bit       pop;
    bit [0:0] poch;
    bit [1:0] flush;
    bit       clr;
    bit       chk;
    bit [7:0] head;
    int       u0;
    int       u1;
    bit [1:0] ovf;
    bit [1:0] unf;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  function automatic vec_t mk(bit push, bit [0:0] pch, bit [7:0] din, bit pop, bit [0:0] poch,
                              bit [1:0] flush, bit clr, bit chk, bit [7:0] head,
                              int u0, int u1, bit [1:0] ovf, bit [1:0] unf);
    vec_t v;
    v.push = push; v.pch = pch; v.din = din; v.pop = pop; v.poch = poch;
    v.flush = flush; v.clr = clr; v.chk = chk; v.head = head;
    v.u0 = u0; v.u1 = u1; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every status output against the reference queues.
  task automatic check_output(input string tag);
    logic [NCHAN*UW-1:0] eu;
    logic [NCHAN-1:0]    ee, ef, ea;
    for (int c = 0; c < NCHAN; c++) begin
      int sz = mq[c].size();
      eu[c*UW +: UW] = UW'(sz);
      ee[c] = (sz == 0);
      ef[c] = (sz == DEPTH);
      ea[c] = (sz >= AFULL);
    end
    check({tag, "_usage"}, 32'(usage_o), 32'(eu));
    check({tag, "_empty"}, 32'(empty_o), 32'(ee));
    check({tag, "_full"},  32'(full_o),  32'(ef));
    check({tag, "_afull"}, 32'(afull_o), 32'(ea));
    check({tag, "_ovf"},   32'(ovf_o),   32'(movf));
    check({tag, "_unf"},   32'(unf_o),   32'(munf));
  endtask

  // Drive one cycle, check the fall-through head before the edge, then
  // advance the model by the FIFO rules and compare status after the edge.
  task automatic apply_stimulus(input bit push, input bit [0:0] pch, input bit [7:0] din,
                                input bit pop, input bit [0:0] poch,
                                input bit [1:0] flush, input bit clr, input string tag);
    bit pop_req, pop_ok, push_req, push_ok;
    @(negedge clk_i);
    push_i = push; pushchan_i = pch; data_i = din;
    pop_i = pop; popchan_i = poch; flush_i = flush; clrerr_i = clr;
    #1;
    head_seen = data_o;
    if (mq[poch].size() > 0)
      check({tag, "_head"}, 32'(data_o), 32'(mq[poch][0]));
    pop_req  = pop && !flush[poch];
    pop_ok   = pop_req && (mq[poch].size() > 0);
    push_req = push && !flush[pch];
    push_ok  = push_req && ((mq[pch].size() < DEPTH) || (pop_ok && (poch == pch)));
    @(posedge clk_i);
    #1;
    if (clr) begin
      movf = '0;
      munf = '0;
    end
    if (push_req && !push_ok) movf[pch] = 1'b1;
    if (pop_req && !pop_ok)   munf[poch] = 1'b1;
    if (pop_ok)  void'(mq[poch].pop_front());
    if (push_ok) mq[pch].push_back(din);
    for (int c = 0; c < NCHAN; c++)
      if (flush[c]) mq[c].delete();
    check_output(tag);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("tbl%0d", idx);
    apply_stimulus(v.push, v.pch, v.din, v.pop, v.poch, v.flush, v.clr, tag);
    if (v.chk) check({tag, "_tblhead"}, 32'(head_seen), 32'(v.head));
    check({tag, "_tblusage"}, 32'(usage_o), 32'({3'(v.u1), 3'(v.u0)}));
    check({tag, "_tblfull"},  32'(full_o),  32'({v.u1 == 4, v.u0 == 4}));
    check({tag, "_tblempty"}, 32'(empty_o), 32'({v.u1 == 0, v.u0 == 0}));
    check({tag, "_tblafull"}, 32'(afull_o), 32'({v.u1 >= 3, v.u0 >= 3}));
    check({tag, "_tblovf"},   32'(ovf_o),   32'(v.ovf));
    check({tag, "_tblunf"},   32'(unf_o),   32'(v.unf));
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      bit [1:0] fl;
      fl[0] = ($urandom_range(0, 19) == 0);
      fl[1] = ($urandom_range(0, 19) == 0);
      apply_stimulus($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
                     8'($urandom), $urandom_range(0, 99) < 50, 1'($urandom_range(0, 1)),
                     fl, $urandom_range(0, 24) == 0, "rnd");
    end
  endtask

  initial begin
    rst_i = 1'b0;
    push_i = 0; pop_i = 0; clrerr_i = 0; flush_i = '0;
    pushchan_i = '0; popchan_i = '0; data_i = '0;
    movf = '0; munf = '0;

    // push,pch,din,pop,poch,flush,clr,chk,head,u0,u1,ovf,unf
    tbl_a.push_back(mk(1, 0, 8'hA1, 0, 0, 2'b00, 0, 0, 8'h00, 1, 0, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 0, 8'hA2, 0, 0, 2'b00, 0, 1, 8'hA1, 2, 0, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 0, 8'hA3, 0, 0, 2'b00, 0, 1, 8'hA1, 3, 0, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 0, 8'hA4, 0, 0, 2'b00, 0, 0, 8'h00, 4, 0, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 0, 8'hA5, 0, 0, 2'b00, 0, 0, 8'h00, 4, 0, 2'b01, 2'b00));
    tbl_a.push_back(mk(0, 0, 8'h00, 1, 0, 2'b00, 0, 1, 8'hA1, 3, 0, 2'b01, 2'b00));
    tbl_a.push_back(mk(0, 0, 8'h00, 1, 0, 2'b00, 0, 1, 8'hA2, 2, 0, 2'b01, 2'b00));
    tbl_a.push_back(mk(0, 0, 8'h00, 1, 0, 2'b00, 0, 1, 8'hA3, 1, 0, 2'b01, 2'b00));
    tbl_a.push_back(mk(0, 0, 8'h00, 1, 0, 2'b00, 0, 1, 8'hA4, 0, 0, 2'b01, 2'b00));
    tbl_a.push_back(mk(0, 0, 8'h00, 0, 0, 2'b00, 1, 0, 8'h00, 0, 0, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 0, 8'h10, 0, 0, 2'b00, 0, 0, 8'h00, 1, 0, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 1, 8'h20, 0, 0, 2'b00, 0, 0, 8'h00, 1, 1, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 0, 8'h11, 0, 0, 2'b00, 0, 0, 8'h00, 2, 1, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 1, 8'h21, 0, 0, 2'b00, 0, 0, 8'h00, 2, 2, 2'b00, 2'b00));
    tbl_a.push_back(mk(0, 0, 8'h00, 1, 1, 2'b00, 0, 1, 8'h20, 2, 1, 2'b00, 2'b00));
    tbl_a.push_back(mk(0, 0, 8'h00, 1, 1, 2'b00, 0, 1, 8'h21, 2, 0, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 1, 8'h30, 0, 1, 2'b00, 0, 0, 8'h00, 2, 1, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 1, 8'h31, 0, 1, 2'b00, 0, 0, 8'h00, 2, 2, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 1, 8'h32, 0, 1, 2'b00, 0, 0, 8'h00, 2, 3, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 1, 8'h33, 0, 1, 2'b00, 0, 0, 8'h00, 2, 4, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 1, 8'h55, 1, 1, 2'b00, 0, 1, 8'h30, 2, 4, 2'b00, 2'b00));
    tbl_a.push_back(mk(0, 0, 8'h00, 1, 1, 2'b00, 0, 1, 8'h31, 2, 3, 2'b00, 2'b00));
    tbl_a.push_back(mk(0, 0, 8'h00, 1, 1, 2'b00, 0, 1, 8'h32, 2, 2, 2'b00, 2'b00));
    tbl_a.push_back(mk(0, 0, 8'h00, 1, 1, 2'b00, 0, 1, 8'h33, 2, 1, 2'b00, 2'b00));
    tbl_a.push_back(mk(0, 0, 8'h00, 1, 1, 2'b00, 0, 1, 8'h55, 2, 0, 2'b00, 2'b00));
    tbl_a.push_back(mk(0, 0, 8'h00, 1, 0, 2'b00, 0, 1, 8'h10, 1, 0, 2'b00, 2'b00));
    tbl_a.push_back(mk(0, 0, 8'h00, 1, 0, 2'b00, 0, 1, 8'h11, 0, 0, 2'b00, 2'b00));
    tbl_a.push_back(mk(1, 0, 8'h77, 1, 0, 2'b00, 0, 0, 8'h00, 1, 0, 2'b00, 2'b01));

    tbl_b.push_back(mk(1, 0, 8'h90, 0, 0, 2'b00, 0, 1, 8'h89, 2, 0, 2'b00, 2'b01));
    tbl_b.push_back(mk(1, 0, 8'h91, 0, 0, 2'b00, 0, 1, 8'h89, 3, 0, 2'b00, 2'b01));
    tbl_b.push_back(mk(1, 0, 8'h92, 0, 0, 2'b01, 0, 1, 8'h89, 0, 0, 2'b00, 2'b01));
    tbl_b.push_back(mk(1, 1, 8'h40, 0, 1, 2'b00, 0, 0, 8'h00, 0, 1, 2'b00, 2'b01));
    tbl_b.push_back(mk(1, 1, 8'h41, 0, 1, 2'b00, 0, 1, 8'h40, 0, 2, 2'b00, 2'b01));
    tbl_b.push_back(mk(1, 1, 8'h42, 0, 1, 2'b00, 0, 1, 8'h40, 0, 3, 2'b00, 2'b01));
    tbl_b.push_back(mk(1, 1, 8'h43, 0, 1, 2'b00, 0, 1, 8'h40, 0, 4, 2'b00, 2'b01));
    tbl_b.push_back(mk(1, 1, 8'h44, 0, 1, 2'b00, 1, 1, 8'h40, 0, 4, 2'b10, 2'b00));

    repeat (2) @(posedge clk_i);
    #1;
    check_output("reset");
    @(negedge clk_i);
    rst_i = 1'b1;

    foreach (tbl_a[i]) run_vec(tbl_a[i], i);

    // Push and pop together on ch0 across the index wrap; usage must stay 1.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] exp_head;
      exp_head = (i == 0) ? 8'h77 : 8'(8'h80 + i - 1);
      apply_stimulus(1, 0, 8'(8'h80 + i), 1, 0, 2'b00, 0, "wrap");
      check("wrap_tblhead", 32'(head_seen), 32'(exp_head));
      check("wrap_tblusage", 32'(usage_o), 32'(6'b000_001));
    end

    foreach (tbl_b[i]) run_vec(tbl_b[i], 100 + i);

    random_traffic(400);

    // Reset asserted between edges must clear outputs before the next edge.
    @(negedge clk_i);
    push_i = 1; pushchan_i = 0; data_i = 8'hEE; pop_i = 1; popchan_i = 1;
    #2;
    rst_i = 1'b0;
    #1;
    check("async_usage", 32'(usage_o), 32'(0));
    check("async_empty", 32'(empty_o), 32'(2'b11));
    check("async_full",  32'(full_o),  32'(0));
    check("async_afull", 32'(afull_o), 32'(0));
    check("async_ovf",   32'(ovf_o),   32'(0));
    check("async_unf",   32'(unf_o),   32'(0));
    push_i = 0; pop_i = 0; flush_i = '0; clrerr_i = 0;
    for (int c = 0; c < NCHAN; c++) mq[c].delete();
    movf = '0; munf = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_output("postrst");

    random_traffic(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
